wb_arbiter_2m: RTL and testbench
================================

WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 The block SHALL have parameter WB_BUS_WIDTH, default 32, data width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter WB_ADDR_WIDTH, default 32, address width in bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, the number of stalled bus cycles before abort, range 1..65535.
REQ-004 wb_clk_i  in  1  single clock; the only clock.
REQ-005 wb_reset_i  in  1  synchronous, active-high reset.
REQ-006 mN_data_i / mN_addr_i / mN_sel_i  in  WB_BUS_WIDTH / WB_ADDR_WIDTH / WB_BUS_WIDTH/8  master N (N=0,1) request data, address, byte select.
REQ-007 mN_cyc_i, mN_stb_i, mN_we_i, mN_lock_i  in  1 each  master N cycle, strobe, write enable, lock.
REQ-008 mN_data_o  out  WB_BUS_WIDTH  read data to master N.
REQ-009 mN_ack_o, mN_stall_o, mN_err_o, mN_rty_o  out  1 each  responses to master N.
REQ-010 s_data_o / s_addr_o / s_sel_o / s_cyc_o / s_stb_o / s_we_o / s_lock_o  out  shared slave bus, same widths as the master-side signals.
REQ-011 s_data_i / s_ack_i / s_stall_i / s_err_i / s_rty_i  in  wired-OR slave responses.

Function
REQ-012 The state machine SHALL have three states: IDLE, BUSY, ABORT; registers: owner (1 bit), last (1 bit), wdog (16 bits).
REQ-013 In IDLE, when any mN_cyc_i=1, the block SHALL register the grant: a single requester wins; if both request, the master != last wins (round-robin); next state BUSY, owner<=winner, last<=winner, wdog<=0.
REQ-014 Grant latency SHALL be exactly one cycle: s_cyc_o rises in the cycle after the first cycle in which mN_cyc_i is sampled high in IDLE.
REQ-015 In BUSY, s_* outputs SHALL combinationally equal the owner's inputs; owner's data/ack/stall/err/rty outputs SHALL combinationally equal s_* inputs.
REQ-016 A non-owner master, and both masters in IDLE and ABORT, SHALL see stall=1, ack=0, rty=0, data=0; err=0 except per REQ-020.
REQ-017 In IDLE, all s_* outputs SHALL be 0.
REQ-018 BUSY SHALL exit to IDLE when the owner's cyc_i=0 and lock_i=0 in the same cycle; while owner lock_i=1, the grant SHALL be held even if cyc_i drops, with s_cyc_o=0 and s_stb_o=0 in those cycles.
REQ-019 Watchdog: in BUSY, wdog SHALL reset to 0 on any cycle with s_ack_i|s_err_i|s_rty_i, or with owner stb_i=0 and no response; otherwise wdog SHALL increment, saturating at 16 bits.
REQ-020 When wdog reaches TIMEOUT, next state SHALL be ABORT: s_cyc_o=0 and s_stb_o=0, with owner err_o=1 for exactly the first ABORT cycle.
REQ-021 ABORT SHALL exit to IDLE when the owner's cyc_i=0 and lock_i=0.
REQ-022 A non-owner request SHALL never be lost: it remains pending until granted, and with both masters requesting continuously grants SHALL alternate.
REQ-023 Simultaneous owner release and other-master request SHALL pass through one IDLE cycle before the new grant.

Reset
REQ-024 When wb_reset_i=1 at a clock edge, the block SHALL set state=IDLE, owner=0, last=1, wdog=0, regardless of the current state, including mid-transfer.
REQ-025 During and after reset, before any grant: all s_* outputs 0; mN_stall_o=1; mN_ack_o, mN_err_o, mN_rty_o and mN_data_o all 0.

Verification
REQ-026 Only m0 cyc/stb write addr 0x1000, data 0xA5A5A5A5, slave acks next cycle -> s_cyc_o high 1 cycle after request; m0_ack_o=1; m1_stall_o=1 throughout.
REQ-027 m0 and m1 request in the same cycle after reset, each doing one transfer, repeated 4 times -> grant order m0,m1,m0,m1 with one IDLE cycle between grants.
REQ-028 m1 owner with lock=1 drops cyc for 3 cycles while m0 requests -> m0 stays stalled until m1 lock=0; then IDLE, then m0 granted.
REQ-029 TIMEOUT=4; m0 stb held and slave never acks -> m0_err_o=1 for one cycle after 4 counted cycles; s_cyc_o=0 in ABORT; IDLE after m0 drops cyc.
REQ-030 Reset asserted mid-transfer with m1 owner -> next cycle s_cyc_o=0 and both stall=1; with both requesting after reset, m0 is granted first.

Source files
------------

// File: rtl/wb_arbiter_2m_if.sv
// Bus bundle between two Wishbone masters, the arbiter and the shared slave.
// Modport 'slave' is the arbiter's view; modport 'master' is the environment driving masters and slave.
interface wb_arbiter_2m_if #(
  parameter int WB_BUS_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH = 32
) ();
  // Handshake: a master holds cyc_i for the whole bus cycle; each beat is
  // stb_i while stall_o=0, completed by exactly one of ack/err/rty.
  logic [WB_BUS_WIDTH-1:0]   m0_data_i, m1_data_i, m0_data_o, m1_data_o;
  logic [WB_ADDR_WIDTH-1:0]  m0_addr_i, m1_addr_i;
  logic [WB_BUS_WIDTH/8-1:0] m0_sel_i, m1_sel_i;
  logic m0_cyc_i, m0_stb_i, m0_we_i, m0_lock_i;
  logic m1_cyc_i, m1_stb_i, m1_we_i, m1_lock_i;
  logic m0_ack_o, m0_stall_o, m0_err_o, m0_rty_o;
  logic m1_ack_o, m1_stall_o, m1_err_o, m1_rty_o;

  logic [WB_BUS_WIDTH-1:0]   s_data_o, s_data_i;
  logic [WB_ADDR_WIDTH-1:0]  s_addr_o;
  logic [WB_BUS_WIDTH/8-1:0] s_sel_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_lock_o;
  logic s_ack_i, s_stall_i, s_err_i, s_rty_i;

  modport slave (
    input  m0_data_i, m0_addr_i, m0_sel_i, m0_cyc_i, m0_stb_i, m0_we_i, m0_lock_i,
    input  m1_data_i, m1_addr_i, m1_sel_i, m1_cyc_i, m1_stb_i, m1_we_i, m1_lock_i,
    output m0_data_o, m0_ack_o, m0_stall_o, m0_err_o, m0_rty_o,
    output m1_data_o, m1_ack_o, m1_stall_o, m1_err_o, m1_rty_o,
    output s_data_o, s_addr_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o, s_lock_o,
    input  s_data_i, s_ack_i, s_stall_i, s_err_i, s_rty_i
  );

  modport master (
    output m0_data_i, m0_addr_i, m0_sel_i, m0_cyc_i, m0_stb_i, m0_we_i, m0_lock_i,
    output m1_data_i, m1_addr_i, m1_sel_i, m1_cyc_i, m1_stb_i, m1_we_i, m1_lock_i,
    input  m0_data_o, m0_ack_o, m0_stall_o, m0_err_o, m0_rty_o,
    input  m1_data_o, m1_ack_o, m1_stall_o, m1_err_o, m1_rty_o,
    input  s_data_o, s_addr_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o, s_lock_o,
    output s_data_i, s_ack_i, s_stall_i, s_err_i, s_rty_i
  );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter with bus lock and a stall watchdog.
// The grant is registered; data paths through the owner are combinational.
module wb_arbiter_2m #(
  parameter int WB_BUS_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int TIMEOUT       = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_reset_i,
  wb_arbiter_2m_if.slave    bus,
  output logic [1:0]        state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ABORT = 2'd2} state_t;

  localparam logic [15:0] TIMEOUT16 = 16'(TIMEOUT);

  state_t      state_q;
  logic        owner_q, last_q, err_q;
  logic [15:0] wdog_q, wdog_inc;

  logic                      own_cyc, own_stb, own_we, own_lock;
  logic [WB_BUS_WIDTH-1:0]   own_data;
  logic [WB_ADDR_WIDTH-1:0]  own_addr;
  logic [WB_BUS_WIDTH/8-1:0] own_sel;
  logic                      winner, resp, busy, g0, g1;

  always_comb begin
    own_cyc  = owner_q ? bus.m1_cyc_i  : bus.m0_cyc_i;
    own_stb  = owner_q ? bus.m1_stb_i  : bus.m0_stb_i;
    own_we   = owner_q ? bus.m1_we_i   : bus.m0_we_i;
    own_lock = owner_q ? bus.m1_lock_i : bus.m0_lock_i;
    own_data = owner_q ? bus.m1_data_i : bus.m0_data_i;
    own_addr = owner_q ? bus.m1_addr_i : bus.m0_addr_i;
    own_sel  = owner_q ? bus.m1_sel_i  : bus.m0_sel_i;
  end

  // With both requesting, the master that did not own the bus last wins.
  assign winner   = (bus.m0_cyc_i && bus.m1_cyc_i) ? ~last_q : bus.m1_cyc_i;
  assign resp     = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
  assign wdog_inc = (wdog_q == 16'hFFFF) ? wdog_q : wdog_q + 16'd1;

  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wdog_q  <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.m0_cyc_i || bus.m1_cyc_i) begin
            state_q <= BUSY;
            owner_q <= winner;
            last_q  <= winner;
            wdog_q  <= 16'd0;
          end
        end
        BUSY: begin
          if (!own_cyc && !own_lock) begin
            state_q <= IDLE;
          end else if (resp || !own_stb) begin
            wdog_q <= 16'd0;
          end else begin
            wdog_q <= wdog_inc;
            // Abort in the cycle whose count would reach TIMEOUT.
            if (wdog_inc >= TIMEOUT16) begin
              state_q <= ABORT;
              err_q   <= 1'b1;
            end
          end
        end
        ABORT: begin
          if (!own_cyc && !own_lock) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state_o = state_q;
  assign busy    = (state_q == BUSY);
  assign g0      = busy && !owner_q;
  assign g1      = busy &&  owner_q;

  // While a locked owner has dropped cyc, the grant is held but the slave sees no cycle.
  assign bus.s_cyc_o  = busy && own_cyc;
  assign bus.s_stb_o  = busy && own_cyc && own_stb;
  assign bus.s_we_o   = busy && own_we;
  assign bus.s_lock_o = busy && own_lock;
  assign bus.s_data_o = busy ? own_data : '0;
  assign bus.s_addr_o = busy ? own_addr : '0;
  assign bus.s_sel_o  = busy ? own_sel  : '0;

  assign bus.m0_data_o  = g0 ? bus.s_data_i : '0;
  assign bus.m0_ack_o   = g0 && bus.s_ack_i;
  assign bus.m0_stall_o = g0 ? bus.s_stall_i : 1'b1;
  assign bus.m0_err_o   = (g0 && bus.s_err_i) || (err_q && !owner_q);
  assign bus.m0_rty_o   = g0 && bus.s_rty_i;

  assign bus.m1_data_o  = g1 ? bus.s_data_i : '0;
  assign bus.m1_ack_o   = g1 && bus.s_ack_i;
  assign bus.m1_stall_o = g1 ? bus.s_stall_i : 1'b1;
  assign bus.m1_err_o   = (g1 && bus.s_err_i) || (err_q && owner_q);
  assign bus.m1_rty_o   = g1 && bus.s_rty_i;
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: vector table for grant/round-robin behaviour,
// plus hand sequences for lock hold, watchdog abort and mid-transfer reset.
module tb_wb_arbiter_2m;
  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [31:0] W0 = 32'hA5A5_A5A5;
  localparam logic [31:0] W1 = 32'h5A5A_5A5A;
  localparam logic [31:0] D  = 32'hDEAD_BEEF;
  localparam logic [2:0] REQ = 3'b110, OFF = 3'b000;           // {cyc,stb,lock}
  localparam logic [2:0] STL = 3'b010, ACK = 3'b100, OWN = 3'b000; // {ack,stall,err}

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m_if #(.WB_BUS_WIDTH(32), .WB_ADDR_WIDTH(32)) bus ();

  wb_arbiter_2m #(.WB_BUS_WIDTH(32), .WB_ADDR_WIDTH(32), .TIMEOUT(4)) dut (
    .wb_clk_i  (clk),
    .wb_reset_i(rst),
    .bus       (bus),
    .state_o   (state)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  m0, m1;
    logic        ack;
    logic [1:0]  st;
    logic [1:0]  e_s;     // {s_cyc_o, s_stb_o}
    logic [31:0] e_addr;
    logic [2:0]  e_m0;
    logic [31:0] e_d0;
    logic [2:0]  e_m1;
    logic [31:0] e_d1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [2:0] m0, input logic [2:0] m1,
                              input logic ack, input logic [1:0] st, input logic [1:0] es,
                              input logic [31:0] ea, input logic [2:0] em0, input logic [31:0] ed0,
                              input logic [2:0] em1, input logic [31:0] ed1);
    vec_t v;
    v.rst = r; v.m0 = m0; v.m1 = m1; v.ack = ack; v.st = st; v.e_s = es; v.e_addr = ea;
    v.e_m0 = em0; v.e_d0 = ed0; v.e_m1 = em1; v.e_d1 = ed1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] m0, input logic [2:0] m1, input logic ack);
    {bus.m0_cyc_i, bus.m0_stb_i, bus.m0_lock_i} = m0;
    {bus.m1_cyc_i, bus.m1_stb_i, bus.m1_lock_i} = m1;
    bus.s_ack_i = ack;
  endtask

  task automatic chk_m0(input string tag, input logic [2:0] e, input logic [31:0] d);
    chk({tag, "_m0_ack"},   32'(bus.m0_ack_o),   32'(e[2]));
    chk({tag, "_m0_stall"}, 32'(bus.m0_stall_o), 32'(e[1]));
    chk({tag, "_m0_err"},   32'(bus.m0_err_o),   32'(e[0]));
    chk({tag, "_m0_data"},  bus.m0_data_o,       d);
  endtask

  task automatic chk_m1(input string tag, input logic [2:0] e, input logic [31:0] d);
    chk({tag, "_m1_ack"},   32'(bus.m1_ack_o),   32'(e[2]));
    chk({tag, "_m1_stall"}, 32'(bus.m1_stall_o), 32'(e[1]));
    chk({tag, "_m1_err"},   32'(bus.m1_err_o),   32'(e[0]));
    chk({tag, "_m1_data"},  bus.m1_data_o,       d);
  endtask

  initial begin
    rst = 1'b1;
    bus.m0_data_i = W0; bus.m0_addr_i = A0; bus.m0_sel_i = 4'hF; bus.m0_we_i = 1'b1;
    bus.m1_data_i = W1; bus.m1_addr_i = A1; bus.m1_sel_i = 4'h3; bus.m1_we_i = 1'b0;
    bus.s_data_i = D; bus.s_stall_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
    drive(OFF, OFF, 1'b0);

    // Round-robin table: single transfer, reset, then four alternating grants.
    vecs.push_back(mk(0, REQ, OFF, 0, 0, 2'b00, 0,  STL, 0, STL, 0));
    vecs.push_back(mk(0, REQ, OFF, 1, 1, 2'b11, A0, ACK, D, STL, 0));
    vecs.push_back(mk(0, OFF, OFF, 0, 1, 2'b00, A0, OWN, D, STL, 0));
    vecs.push_back(mk(1, OFF, OFF, 0, 0, 2'b00, 0,  STL, 0, STL, 0));
    vecs.push_back(mk(0, REQ, REQ, 0, 0, 2'b00, 0,  STL, 0, STL, 0));
    vecs.push_back(mk(0, REQ, REQ, 1, 1, 2'b11, A0, ACK, D, STL, 0));
    vecs.push_back(mk(0, OFF, REQ, 0, 1, 2'b00, A0, OWN, D, STL, 0));
    vecs.push_back(mk(0, REQ, REQ, 0, 0, 2'b00, 0,  STL, 0, STL, 0));
    vecs.push_back(mk(0, REQ, REQ, 1, 1, 2'b11, A1, STL, 0, ACK, D));
    vecs.push_back(mk(0, REQ, OFF, 0, 1, 2'b00, A1, STL, 0, OWN, D));
    vecs.push_back(mk(0, REQ, REQ, 0, 0, 2'b00, 0,  STL, 0, STL, 0));
    vecs.push_back(mk(0, REQ, REQ, 1, 1, 2'b11, A0, ACK, D, STL, 0));
    vecs.push_back(mk(0, OFF, REQ, 0, 1, 2'b00, A0, OWN, D, STL, 0));
    vecs.push_back(mk(0, REQ, REQ, 0, 0, 2'b00, 0,  STL, 0, STL, 0));
    vecs.push_back(mk(0, REQ, REQ, 1, 1, 2'b11, A1, STL, 0, ACK, D));
    vecs.push_back(mk(0, OFF, OFF, 0, 1, 2'b00, A1, STL, 0, OWN, D));
    vecs.push_back(mk(0, OFF, OFF, 0, 0, 2'b00, 0,  STL, 0, STL, 0));

    // Reset state
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    chk("rst_s_addr", bus.s_addr_o, 32'd0);
    chk("rst_s_data", bus.s_data_o, 32'd0);
    chk_m0("rst", STL, 0);
    chk_m1("rst", STL, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("row%0d", i);
      rst = vecs[i].rst;
      drive(vecs[i].m0, vecs[i].m1, vecs[i].ack);
      #1;
      chk({tag, "_state"}, 32'(state), 32'(vecs[i].st));
      chk({tag, "_s_cyc"}, 32'(bus.s_cyc_o), 32'(vecs[i].e_s[1]));
      chk({tag, "_s_stb"}, 32'(bus.s_stb_o), 32'(vecs[i].e_s[0]));
      chk({tag, "_s_addr"}, bus.s_addr_o, vecs[i].e_addr);
      chk_m0(tag, vecs[i].e_m0, vecs[i].e_d0);
      chk_m1(tag, vecs[i].e_m1, vecs[i].e_d1);
      tick();
    end
    rst = 1'b0;

    // Locked m1 holds the grant with cyc dropped while m0 waits.
    drive(OFF, 3'b111, 0); #1;
    chk("lk_idle_state", 32'(state), 32'd0);
    tick();
    drive(REQ, 3'b111, 1); #1;
    chk("lk_s_cyc", 32'(bus.s_cyc_o), 32'd1);
    chk("lk_s_lock", 32'(bus.s_lock_o), 32'd1);
    chk("lk_s_data", bus.s_data_o, W1);
    chk("lk_m1_ack", 32'(bus.m1_ack_o), 32'd1);
    chk("lk_m0_stall", 32'(bus.m0_stall_o), 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(REQ, 3'b001, 0); #1;
      chk($sformatf("lk_hold%0d_state", k), 32'(state), 32'd1);
      chk($sformatf("lk_hold%0d_s_cyc", k), 32'(bus.s_cyc_o), 32'd0);
      chk($sformatf("lk_hold%0d_s_stb", k), 32'(bus.s_stb_o), 32'd0);
      chk($sformatf("lk_hold%0d_m0_stall", k), 32'(bus.m0_stall_o), 32'd1);
      tick();
    end
    drive(REQ, OFF, 0); #1;
    chk("lk_rel_state", 32'(state), 32'd1);
    chk("lk_rel_m0_stall", 32'(bus.m0_stall_o), 32'd1);
    tick();
    chk("lk_gap_state", 32'(state), 32'd0);
    chk("lk_gap_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    chk("lk_gap_m0_stall", 32'(bus.m0_stall_o), 32'd1);
    tick();
    drive(REQ, OFF, 1); #1;
    chk("lk_m0_s_cyc", 32'(bus.s_cyc_o), 32'd1);
    chk("lk_m0_s_addr", bus.s_addr_o, A0);
    chk("lk_m0_ack", 32'(bus.m0_ack_o), 32'd1);
    tick();
    drive(OFF, OFF, 0);
    tick();

    // Watchdog: m0 strobes into a slave that never answers.
    bus.s_stall_i = 1'b1;
    drive(REQ, OFF, 0); #1;
    chk("wd_idle_state", 32'(state), 32'd0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("wd_c%0d_state", k), 32'(state), 32'd1);
      chk($sformatf("wd_c%0d_s_cyc", k), 32'(bus.s_cyc_o), 32'd1);
      chk($sformatf("wd_c%0d_m0_err", k), 32'(bus.m0_err_o), 32'd0);
      chk($sformatf("wd_c%0d_m0_stall", k), 32'(bus.m0_stall_o), 32'd1);
      tick();
    end
    chk("wd_ab_state", 32'(state), 32'd2);
    chk("wd_ab_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    chk("wd_ab_s_stb", 32'(bus.s_stb_o), 32'd0);
    chk("wd_ab_m0_err", 32'(bus.m0_err_o), 32'd1);
    chk("wd_ab_m1_err", 32'(bus.m1_err_o), 32'd0);
    chk("wd_ab_m0_stall", 32'(bus.m0_stall_o), 32'd1);
    tick();
    chk("wd_ab2_state", 32'(state), 32'd2);
    chk("wd_ab2_m0_err", 32'(bus.m0_err_o), 32'd0);
    drive(OFF, OFF, 0); #1;
    chk("wd_drop_state", 32'(state), 32'd2);
    tick();
    chk("wd_exit_state", 32'(state), 32'd0);
    bus.s_stall_i = 1'b0;

    // Reset while m1 owns the bus; m0 wins first afterwards.
    drive(OFF, REQ, 0);
    tick();
    chk("mr_m1_s_cyc", 32'(bus.s_cyc_o), 32'd1);
    chk("mr_m1_s_addr", bus.s_addr_o, A1);
    rst = 1'b1;
    drive(REQ, REQ, 0);
    tick();
    rst = 1'b0; #1;
    chk("mr_state", 32'(state), 32'd0);
    chk("mr_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    chk("mr_m0_stall", 32'(bus.m0_stall_o), 32'd1);
    chk("mr_m1_stall", 32'(bus.m1_stall_o), 32'd1);
    tick();
    chk("mr_grant_s_cyc", 32'(bus.s_cyc_o), 32'd1);
    chk("mr_grant_s_addr", bus.s_addr_o, A0);
    chk("mr_grant_m1_stall", 32'(bus.m1_stall_o), 32'd1);
    drive(OFF, OFF, 0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
